// File: rtl/regbank_pkg.sv
// Shared constants and state encoding for the register-bank write arbiter.
// Parameter defaults of the arbiter and its decoder are taken from here.
package regbank_pkg;

    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 16;
    localparam int ADDR_W   = $clog2(NUM_REGS);

    localparam logic [DATA_W-1:0] CLEAR_VALUE_DFLT = 32'h0000_0000;

    typedef enum logic {
        ST_ARB   = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

endpackage

// File: rtl/regbank_onehot_dec.sv
// Combinational index-to-one-hot decoder. It is shared by the grant path and
// the clear path.
module regbank_onehot_dec
    import regbank_pkg::*;
#(
    parameter int N_OUT = NUM_REGS,
    parameter int IDX_W = $clog2(N_OUT)
) (
    input  logic [IDX_W-1:0] idx_i,
    output logic [N_OUT-1:0] onehot_o
);

    always_comb begin
        onehot_o        = '0;
        onehot_o[idx_i] = 1'b1;
    end

endmodule

// File: rtl/regbank_write_arbiter.sv
// Round-robin write arbiter for two requesters onto the register bank's shared
// Din/enable bus, with a built-in sequence that writes CLEAR_VALUE everywhere.
module regbank_write_arbiter #(
    parameter int                DATA_W      = regbank_pkg::DATA_W,
    parameter int                NUM_REGS    = regbank_pkg::NUM_REGS,
    parameter logic [DATA_W-1:0] CLEAR_VALUE = regbank_pkg::CLEAR_VALUE_DFLT
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        a_valid_i,
    input  logic [$clog2(NUM_REGS)-1:0] a_addr_i,
    input  logic [DATA_W-1:0]           a_data_i,
    output logic                        a_ready_o,
    input  logic                        b_valid_i,
    input  logic [$clog2(NUM_REGS)-1:0] b_addr_i,
    input  logic [DATA_W-1:0]           b_data_i,
    output logic                        b_ready_o,
    input  logic                        hold_i,
    input  logic                        clear_start_i,
    output logic                        clear_busy_o,
    output logic [DATA_W-1:0]           wr_data_o,
    output logic [NUM_REGS-1:0]         wr_en_o,
    output logic                        last_grant_o
);
    import regbank_pkg::*;

    localparam int ADDR_W = $clog2(NUM_REGS);

    state_e              state_q, state_d;
    logic                rr_ptr_q, rr_ptr_d;
    logic                last_grant_q, last_grant_d;
    logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
    logic [NUM_REGS-1:0] wr_en_q, wr_en_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;

    logic                grant_ok;
    logic [ADDR_W-1:0]   dec_idx;
    logic [NUM_REGS-1:0] dec_onehot;

    // A clear request in the same cycle pre-empts any grant.
    assign grant_ok  = !rst && (state_q == ST_ARB) && !hold_i && !clear_start_i;
    assign a_ready_o = grant_ok && a_valid_i && (!b_valid_i || !rr_ptr_q);
    assign b_ready_o = grant_ok && b_valid_i && (!a_valid_i ||  rr_ptr_q);

    assign dec_idx = (state_q == ST_CLEAR) ? clr_cnt_q :
                     (b_ready_o ? b_addr_i : a_addr_i);

    regbank_onehot_dec #(
        .N_OUT (NUM_REGS),
        .IDX_W (ADDR_W)
    ) u_dec (
        .idx_i    (dec_idx),
        .onehot_o (dec_onehot)
    );

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        last_grant_d = last_grant_q;
        clr_cnt_d    = clr_cnt_q;
        wr_en_d      = '0;
        wr_data_d    = wr_data_q;

        case (state_q)
            ST_ARB: begin
                if (clear_start_i) begin
                    state_d   = ST_CLEAR;
                    clr_cnt_d = '0;
                end else if (a_ready_o || b_ready_o) begin
                    wr_en_d      = dec_onehot;
                    wr_data_d    = b_ready_o ? b_data_i : a_data_i;
                    rr_ptr_d     = !b_ready_o;
                    last_grant_d = b_ready_o;
                end
            end
            ST_CLEAR: begin
                wr_en_d   = dec_onehot;
                wr_data_d = CLEAR_VALUE;
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == ADDR_W'(NUM_REGS - 1)) begin
                    state_d = ST_ARB;
                end
            end
            default: state_d = ST_ARB;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_ARB;
            rr_ptr_q     <= 1'b0;
            last_grant_q <= 1'b0;
            clr_cnt_q    <= '0;
            wr_en_q      <= '0;
            wr_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            last_grant_q <= last_grant_d;
            clr_cnt_q    <= clr_cnt_d;
            wr_en_q      <= wr_en_d;
            wr_data_q    <= wr_data_d;
        end
    end

    assign clear_busy_o = (state_q == ST_CLEAR);
    assign wr_en_o      = wr_en_q;
    assign wr_data_o    = wr_data_q;
    assign last_grant_o = last_grant_q;

endmodule

// File: tb/tb_regbank_write_arbiter.sv
// Directed bench for regbank_write_arbiter with hand-computed expectations and
// a behavioural register bank fed from wr_en/wr_data.
module tb_regbank_write_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_valid, b_valid, hold, clear_start;
    logic [3:0]  a_addr, b_addr;
    logic [31:0] a_data, b_data;
    logic        a_ready, b_ready, clear_busy, last_grant;
    logic [31:0] wr_data;
    logic [15:0] wr_en;
    logic [31:0] bank [16];

    int n_vec = 0;
    int n_err = 0;

    regbank_write_arbiter dut (
        .clk           (clk),
        .rst           (rst),
        .a_valid_i     (a_valid),
        .a_addr_i      (a_addr),
        .a_data_i      (a_data),
        .a_ready_o     (a_ready),
        .b_valid_i     (b_valid),
        .b_addr_i      (b_addr),
        .b_data_i      (b_data),
        .b_ready_o     (b_ready),
        .hold_i        (hold),
        .clear_start_i (clear_start),
        .clear_busy_o  (clear_busy),
        .wr_data_o     (wr_data),
        .wr_en_o       (wr_en),
        .last_grant_o  (last_grant)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        for (int i = 0; i < 16; i++)
            if (wr_en[i]) bank[i] <= wr_data;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; hold = 1'b0; clear_start = 1'b0;
        a_valid = 1'b1; a_addr = 4'd3; a_data = 32'h1;
        b_valid = 1'b0; b_addr = 4'd0; b_data = 32'h0;

        // reset held with A pending
        for (int i = 0; i < 2; i++) begin
            #1 chk("rst_a_ready", {31'b0, a_ready}, 32'd0);
            tick();
            chk("rst_wr_en", {16'b0, wr_en}, 32'd0);
            chk("rst_wr_data", wr_data, 32'd0);
            chk("rst_clear_busy", {31'b0, clear_busy}, 32'd0);
            chk("rst_last_grant", {31'b0, last_grant}, 32'd0);
        end
        rst = 1'b0; a_valid = 1'b0;
        tick();

        // single requester A
        a_valid = 1'b1; a_addr = 4'd5; a_data = 32'hDEAD_BEEF;
        #1 chk("single_a_ready", {31'b0, a_ready}, 32'd1);
        chk("single_b_ready", {31'b0, b_ready}, 32'd0);
        tick();
        a_valid = 1'b0;
        chk("single_wr_en", {16'b0, wr_en}, 32'h0020);
        chk("single_wr_data", wr_data, 32'hDEAD_BEEF);
        chk("single_last_grant", {31'b0, last_grant}, 32'd0);
        tick();
        chk("single_wr_en_off", {16'b0, wr_en}, 32'd0);
        chk("single_wr_data_hold", wr_data, 32'hDEAD_BEEF);

        // round-robin from reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        a_valid = 1'b1; a_addr = 4'd1; a_data = 32'hA1;
        b_valid = 1'b1; b_addr = 4'd2; b_data = 32'hB2;
        for (int i = 0; i < 4; i++) begin
            #1 chk("rr_a_ready", {31'b0, a_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
            chk("rr_b_ready", {31'b0, b_ready}, (i % 2 == 1) ? 32'd1 : 32'd0);
            tick();
            chk("rr_wr_en", {16'b0, wr_en}, (i % 2 == 0) ? 32'h0002 : 32'h0004);
            chk("rr_wr_data", wr_data, (i % 2 == 0) ? 32'hA1 : 32'hB2);
            chk("rr_last_grant", {31'b0, last_grant}, (i % 2 == 1) ? 32'd1 : 32'd0);
        end
        a_valid = 1'b0; b_valid = 1'b0;
        tick();
        chk("rr_idle_wr_en", {16'b0, wr_en}, 32'd0);

        // same-address conflict, rr_ptr back on A
        a_valid = 1'b1; a_addr = 4'd7; a_data = 32'h11;
        b_valid = 1'b1; b_addr = 4'd7; b_data = 32'h22;
        #1 chk("same_a_ready", {31'b0, a_ready}, 32'd1);
        chk("same_b_ready0", {31'b0, b_ready}, 32'd0);
        tick();
        a_valid = 1'b0;
        chk("same_wr_en0", {16'b0, wr_en}, 32'h0080);
        chk("same_wr_data0", wr_data, 32'h11);
        #1 chk("same_b_ready", {31'b0, b_ready}, 32'd1);
        tick();
        b_valid = 1'b0;
        chk("same_wr_en1", {16'b0, wr_en}, 32'h0080);
        chk("same_wr_data1", wr_data, 32'h22);
        tick();
        chk("same_bank_r7", bank[7], 32'h22);

        // hold blocks both requesters
        hold = 1'b1;
        a_valid = 1'b1; a_addr = 4'd3; a_data = 32'h33;
        b_valid = 1'b1; b_addr = 4'd9; b_data = 32'h99;
        for (int i = 0; i < 3; i++) begin
            #1 chk("hold_a_ready", {31'b0, a_ready}, 32'd0);
            chk("hold_b_ready", {31'b0, b_ready}, 32'd0);
            tick();
            chk("hold_wr_en", {16'b0, wr_en}, 32'd0);
        end
        hold = 1'b0;
        #1 chk("unhold_a_ready", {31'b0, a_ready}, 32'd1);
        tick();
        a_valid = 1'b0;
        chk("unhold_wr_en_a", {16'b0, wr_en}, 32'h0008);
        #1 chk("unhold_b_ready", {31'b0, b_ready}, 32'd1);
        tick();
        b_valid = 1'b0;
        chk("unhold_wr_en_b", {16'b0, wr_en}, 32'h0200);
        chk("unhold_wr_data_b", wr_data, 32'h99);

        // clear sequence with A pending; a second clear_start mid-way is ignored
        a_valid = 1'b1; a_addr = 4'd4; a_data = 32'h55;
        clear_start = 1'b1;
        #1 chk("clr_start_a_ready", {31'b0, a_ready}, 32'd0);
        tick();
        clear_start = 1'b0;
        for (int k = 0; k < 16; k++) begin
            clear_start = (k == 8);
            #1 chk("clr_busy", {31'b0, clear_busy}, 32'd1);
            chk("clr_a_ready", {31'b0, a_ready}, 32'd0);
            tick();
            chk("clr_wr_en", {16'b0, wr_en}, 32'd1 << k);
            chk("clr_wr_data", wr_data, 32'd0);
        end
        clear_start = 1'b0;
        #1 chk("clr_done_busy", {31'b0, clear_busy}, 32'd0);
        chk("clr_done_a_ready", {31'b0, a_ready}, 32'd1);
        tick();
        a_valid = 1'b0;
        chk("clr_after_wr_en", {16'b0, wr_en}, 32'h0010);
        chk("clr_after_wr_data", wr_data, 32'h55);
        chk("clr_bank_r15", bank[15], 32'd0);

        // reset in the middle of a clear
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        for (int k = 0; k < 6; k++) tick();
        chk("clr6_wr_en", {16'b0, wr_en}, 32'h0020);
        rst = 1'b1;
        tick();
        chk("clr_rst_wr_en", {16'b0, wr_en}, 32'd0);
        chk("clr_rst_busy", {31'b0, clear_busy}, 32'd0);
        rst = 1'b0;
        tick();
        chk("clr_rst_no_resume_busy", {31'b0, clear_busy}, 32'd0);
        chk("clr_rst_no_resume_wr_en", {16'b0, wr_en}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
